// File: rtl/reaction_stats.sv
// rtl/reaction_stats.sv - reaction-time statistics: last, best, truncated mean, trial count
//
// Collects accepted reaction times from the upstream game stage and keeps
// running statistics. The mean is produced by a 16-cycle restoring divider
// (sum / trial_count) after every accepted trial.
//
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous, active-low reset
//   result_valid  in   one-cycle pulse, result_ms is valid
//   result_ms     in   reaction time in ms (0..4095)
//   clear         in   synchronous pulse, wipes all statistics and aborts a division
//   disp_sel      in   display select: 0 last, 1 best, 2 average, 3 trial count
//   disp_value    out  registered selected statistic (1-cycle latency)
//   last_ms       out  latest accepted result
//   best_ms       out  minimum accepted result (0 while no trials)
//   avg_ms        out  truncated mean of accepted results (0 while no trials)
//   trial_count   out  number of accepted trials
//   busy          out  division in progress
//   new_best      out  one-cycle pulse, the last accepted result became best
//   false_start   out  one-cycle pulse, a result below MIN_VALID_MS was rejected
//   overrun       out  one-cycle pulse, a result arrived while busy or full
//   full          out  MAX_TRIALS trials accepted, further results ignored

module reaction_stats #(
    parameter int unsigned MAX_TRIALS   = 8,
    parameter int unsigned MIN_VALID_MS = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        result_valid,
    input  logic [11:0] result_ms,
    input  logic        clear,
    input  logic [1:0]  disp_sel,
    output logic [11:0] disp_value,
    output logic [11:0] last_ms,
    output logic [11:0] best_ms,
    output logic [11:0] avg_ms,
    output logic [3:0]  trial_count,
    output logic        busy,
    output logic        new_best,
    output logic        false_start,
    output logic        overrun,
    output logic        full
);

    localparam logic [11:0] MIN_MS  = 12'(MIN_VALID_MS);
    localparam logic [3:0]  MAX_CNT = 4'(MAX_TRIALS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sum_q, sum_d;
    logic [3:0]  count_q, count_d;
    logic [11:0] last_q, last_d;
    logic [11:0] best_q, best_d;
    logic [11:0] avg_q, avg_d;
    logic [15:0] quo_q, quo_d;
    logic [3:0]  rem_q, rem_d;
    logic [3:0]  step_q, step_d;
    logic        new_best_q, new_best_d;
    logic        false_start_q, false_start_d;
    logic        overrun_q, overrun_d;
    logic [11:0] disp_q, disp_d;

    // One restoring-division step. quo_q starts as the dividend and is shifted
    // left each cycle, the quotient bits entering from the right. The partial
    // remainder is always below the divisor (at most 15), so four bits hold it.
    logic [4:0]  rem_shift;
    logic        quo_bit;
    logic [4:0]  rem_trial;
    logic [15:0] quo_step;

    always_comb begin
        rem_shift = {rem_q, quo_q[15]};
        quo_bit   = (rem_shift >= {1'b0, count_q});
        rem_trial = quo_bit ? (rem_shift - {1'b0, count_q}) : rem_shift;
        quo_step  = {quo_q[14:0], quo_bit};
    end

    // Acceptance helpers for a new result arriving in IDLE.
    logic [15:0] sum_new;
    logic        takes_best;

    always_comb begin
        sum_new    = sum_q + {4'd0, result_ms};
        takes_best = (count_q == 4'd0) || (result_ms < best_q);
    end

    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        count_d       = count_q;
        last_d        = last_q;
        best_d        = best_q;
        avg_d         = avg_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        step_d        = step_q;
        new_best_d    = 1'b0;
        false_start_d = 1'b0;
        overrun_d     = 1'b0;

        case (disp_sel)
            2'd0:    disp_d = last_q;
            2'd1:    disp_d = best_q;
            2'd2:    disp_d = avg_q;
            default: disp_d = {8'd0, count_q};
        endcase

        if (clear) begin
            // clear wins over everything, including a result on the same edge,
            // which is dropped without raising any flag.
            state_d = S_IDLE;
            sum_d   = 16'd0;
            count_d = 4'd0;
            last_d  = 12'd0;
            best_d  = 12'd0;
            avg_d   = 12'd0;
            quo_d   = 16'd0;
            rem_d   = 4'd0;
            step_d  = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (result_valid) begin
                        if (result_ms >= MIN_MS) begin
                            last_d     = result_ms;
                            sum_d      = sum_new;
                            count_d    = count_q + 4'd1;
                            quo_d      = sum_new;
                            rem_d      = 4'd0;
                            step_d     = 4'd0;
                            new_best_d = takes_best;
                            if (takes_best) begin
                                best_d = result_ms;
                            end
                            state_d = S_DIVIDE;
                        end else begin
                            false_start_d = 1'b1;
                        end
                    end
                end

                S_DIVIDE: begin
                    overrun_d = result_valid;
                    quo_d     = quo_step;
                    rem_d     = rem_trial[3:0];
                    step_d    = step_q + 4'd1;
                    // The sixteenth step produces the final quotient; it always
                    // fits in 12 bits because sum <= count * 4095.
                    if (step_q == 4'd15) begin
                        avg_d   = quo_step[11:0];
                        state_d = (count_q == MAX_CNT) ? S_FULL : S_IDLE;
                    end
                end

                S_FULL: begin
                    overrun_d = result_valid;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            sum_q         <= 16'd0;
            count_q       <= 4'd0;
            last_q        <= 12'd0;
            best_q        <= 12'd0;
            avg_q         <= 12'd0;
            quo_q         <= 16'd0;
            rem_q         <= 4'd0;
            step_q        <= 4'd0;
            new_best_q    <= 1'b0;
            false_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            disp_q        <= 12'd0;
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            count_q       <= count_d;
            last_q        <= last_d;
            best_q        <= best_d;
            avg_q         <= avg_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            step_q        <= step_d;
            new_best_q    <= new_best_d;
            false_start_q <= false_start_d;
            overrun_q     <= overrun_d;
            disp_q        <= disp_d;
        end
    end

    assign disp_value  = disp_q;
    assign last_ms     = last_q;
    assign best_ms     = best_q;
    assign avg_ms      = avg_q;
    assign trial_count = count_q;
    assign busy        = (state_q == S_DIVIDE);
    assign full        = (state_q == S_FULL);
    assign new_best    = new_best_q;
    assign false_start = false_start_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/reaction_stats.md
REACTION_STATS -- requirements
Module: reaction_stats

Interface
REQ-001 Parameter: MAX_TRIALS, default 8, number of accepted trials before the block saturates (legal range 1..15).
REQ-002 Parameter: MIN_VALID_MS, default 100, results below this value are false starts.
REQ-003 Port: clk  in  1  sole clock, all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: result_valid  in  1  one-cycle pulse, reaction time from the upstream game stage is present.
REQ-006 Port: result_ms  in  12  reaction time in ms (0..4095), sampled only when result_valid=1.
REQ-007 Port: clear  in  1  synchronous one-cycle pulse, wipes statistics.
REQ-008 Port: disp_sel  in  2  display source select: 0 last, 1 best, 2 average, 3 trial count.
REQ-009 Port: disp_value  out  12  registered selected statistic for the seven-segment stage.
REQ-010 Port: last_ms / best_ms / avg_ms  out  12 each  latest accepted, minimum accepted, truncated mean.
REQ-011 Port: trial_count  out  4  accepted trials.
REQ-012 Port: busy / new_best / false_start / overrun / full  out  1 each  status flags.

Function
REQ-013 The FSM SHALL have states IDLE, DIVIDE, FULL.
REQ-014 In IDLE, result_valid=1 with result_ms>=MIN_VALID_MS at edge E0: last_ms<=result_ms, sum<=sum+result_ms, trial_count+1, state<=DIVIDE.
REQ-015 At E0, best_ms SHALL load result_ms if trial_count was 0 or result_ms<best_ms (strict; ties do not update).
REQ-016 new_best SHALL be 1 for exactly the cycle after E0 when REQ-015 updated best_ms, including the first trial.
REQ-017 sum SHALL be 16 bits; MAX_TRIALS*4095 fits and sum never wraps.
REQ-018 DIVIDE: restoring division sum/trial_count, one quotient bit per cycle, 16 cycles; avg_ms loads the 12 LSBs of the truncated quotient at edge E16.
REQ-019 busy SHALL be 1 from the cycle after E0 through the cycle ending at E16.
REQ-020 After E16, state SHALL be FULL if trial_count==MAX_TRIALS, else IDLE; full = (state==FULL).
REQ-021 result_valid with result_ms<MIN_VALID_MS in IDLE: statistics unchanged, false_start=1 the following cycle.
REQ-022 result_valid during DIVIDE or FULL: ignored; overrun=1 the following cycle; false-start check not applied.
REQ-023 clear in any state: all statistics zero, division aborted, state<=IDLE at that edge; clear outranks a simultaneous result_valid, which is dropped without any flag.
REQ-024 disp_value SHALL register the disp_sel-selected value each cycle (1-cycle latency); count zero-extended to 12 bits.
REQ-025 While trial_count==0, best_ms and avg_ms SHALL read 0.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE and zero every output and internal register (sum, divider, count), regardless of clock.
REQ-027 Reset asserted mid-DIVIDE SHALL discard the division; first cycle after release behaves as IDLE with zero statistics.
REQ-028 Flag pulses (new_best, false_start, overrun) SHALL not assert on the first cycle after reset release.

Verification
REQ-029 Reset: assert reset mid-run, no clk edge -> all outputs 0 immediately; release -> busy=0, trial_count=0.
REQ-030 Results 300, 200, 250 (each after busy drops) -> last 250, best 200, count 3, avg 250; new_best after 300 and 200 only; a later 200 -> no new_best.
REQ-031 Results 100, 101 -> avg 100 (truncation); result 99 -> false_start pulse, count stays 2; result exactly 100 accepted.
REQ-032 result_valid 5 cycles after an accepted result -> overrun pulse, stats unchanged; avg appears exactly 16 edges after E0 and busy spans exactly 16 cycles.
REQ-033 Eight results of 4095 -> sum 32760, avg 4095, full=1; ninth result -> overrun, no change; clear -> all zero, full=0.
REQ-034 clear at DIVIDE cycle 7 with simultaneous result_valid -> IDLE, all zero, no flags; disp_sel sweep 0..3 -> disp_value tracks one cycle later.
